// File: rtl/parking_space_tracker.sv
// Gate-side occupancy controller: arbitrates entry/exit requests, times the gate
// and keeps a saturating free-space count for the display and lot-full logic.
module parking_space_tracker #(
    parameter logic [3:0] CAPACITY    = 4'd8,
    parameter int         GATE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       exit_req,
    output logic       entry_grant,
    output logic       entry_deny,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open,
    output logic [3:0] free_spaces,
    output logic       full,
    output logic       empty
);

    typedef enum logic [1:0] {IDLE, ENTER, EXIT, HOLD} state_t;

    localparam logic [7:0] GATE_INIT = 8'(GATE_CYCLES);

    state_t     state, state_n;
    logic [7:0] timer, timer_n;
    logic [3:0] free_n;
    logic       served_exit, served_exit_n;
    logic       grant_n, deny_n, ack_n, err_n, gate_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            free_spaces <= CAPACITY;
            served_exit <= 1'b0;
            entry_grant <= 1'b0;
            entry_deny  <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;
            gate_open   <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            free_spaces <= free_n;
            served_exit <= served_exit_n;
            entry_grant <= grant_n;
            entry_deny  <= deny_n;
            exit_ack    <= ack_n;
            exit_err    <= err_n;
            gate_open   <= gate_n;
        end
    end

    always_comb begin
        state_n       = state;
        timer_n       = timer;
        free_n        = free_spaces;
        served_exit_n = served_exit;
        grant_n       = 1'b0;
        deny_n        = 1'b0;
        ack_n         = 1'b0;
        err_n         = 1'b0;
        gate_n        = gate_open;
        case (state)
            IDLE: begin
                // Exit wins; a concurrent entry waits until the exit request is released.
                if (exit_req) begin
                    served_exit_n = 1'b1;
                    if (free_spaces < CAPACITY) begin
                        state_n = EXIT;
                        free_n  = free_spaces + 4'd1;
                        ack_n   = 1'b1;
                        timer_n = GATE_INIT;
                        gate_n  = 1'b1;
                    end else begin
                        state_n = HOLD;
                        err_n   = 1'b1;
                    end
                end else if (entry_req) begin
                    served_exit_n = 1'b0;
                    if (free_spaces != 4'd0) begin
                        state_n = ENTER;
                        free_n  = free_spaces + 4'b1111;
                        grant_n = 1'b1;
                        timer_n = GATE_INIT;
                        gate_n  = 1'b1;
                    end else begin
                        state_n = HOLD;
                        deny_n  = 1'b1;
                    end
                end
            end
            ENTER, EXIT: begin
                if (timer == 8'd1) begin
                    state_n = HOLD;
                    gate_n  = 1'b0;
                end else begin
                    timer_n = timer - 8'd1;
                end
            end
            HOLD: begin
                // One count change per request assertion: wait for the served request to drop.
                if (served_exit ? !exit_req : !entry_req)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign full  = (free_spaces == 4'd0);
    assign empty = (free_spaces == CAPACITY);

endmodule
